ps2_keycode_rx: RTL and testbench
=================================

// Module: ps2_keycode_rx
// PURPOSE
//  PS/2 device-to-host receiver. It sits directly upstream of the PS/2 system-bus controller.
//  - Synchronises and filters the raw keyboard clock and data lines.
//  - Deframes each 11-bit frame (start, 8 data LSB-first, odd parity, stop).
//  - Delivers each good byte as keycode_o with a one-cycle keycode_valid_o strobe.
//  - Raw bytes (incl. 0xE0/0xF0 prefixes) pass through unmodified. Scan-code interpretation is left to software.
// PARAMETERS
//  FILTER_LEN      8      cycles a synchronised kclk level must be stable before the filtered clock follows it
//  TIMEOUT_CYCLES  20000  max clk_i cycles between kclk falling edges inside a frame (2 ms @ 10 MHz)
// PORTS
//  clk_i            in   1  system clock (single clock domain)
//  rst_i            in   1  synchronous, active-high reset
//  kclk_i           in   1  raw PS/2 clock from keyboard (asynchronous)
//  kdata_i          in   1  raw PS/2 data from keyboard (asynchronous)
//  keycode_o        out  8  last correctly received byte
//  keycode_valid_o  out  1  1-cycle strobe: keycode_o updated this cycle
//  parity_err_o     out  1  1-cycle strobe: frame dropped, bad parity
//  frame_err_o      out  1  1-cycle strobe: frame dropped, stop bit = 0 or timeout
// BEHAVIOUR
//  Reset:
//   - All outputs 0; FSM in IDLE; bit counter and timeout counter 0.
//   - Synchronisers and the filtered kclk reset to 1 (idle bus).
//  Input path:
//   - kclk_i and kdata_i each pass through a 2-flop synchroniser.
//   - Filtered kclk takes the new level after FILTER_LEN consecutive cycles of the synced value differing from it.
//   - Shorter glitches are ignored.
//   - fall_stb = filtered kclk 1->0, one cycle wide.
//   - On fall_stb, kdata is sampled from its synchroniser.
//  FSM, advancing only on fall_stb (timeout excepted):
//   - IDLE:   sampled 0 -> DATA, bit_cnt=0; sampled 1 -> stay IDLE (no error).
//   - DATA:   shift sample into shreg[7] (right shift, LSB first), bit_cnt++; after the 8th bit -> PARITY.
//   - PARITY: store sample as par -> STOP.
//   - STOP:   -> IDLE, with exactly one of:
//     - sample=1 and ^{shreg,par}==1: keycode_o<=shreg and keycode_valid_o=1 for the next cycle.
//     - sample=1 and parity bad: parity_err_o=1.
//     - sample=0: frame_err_o=1 (takes priority over parity).
//  Output timing:
//   - Strobes are registered: high the cycle after the STOP fall_stb, for exactly 1 cycle.
//   - keycode_o holds its value until the next good frame. Errors never modify it.
//  Timeout:
//   - In DATA/PARITY/STOP, the counter clears on each fall_stb and otherwise increments.
//   - Reaching TIMEOUT_CYCLES-1 forces IDLE and pulses frame_err_o for 1 cycle.
//   - In IDLE the counter is held at 0.
//  Reset mid-frame: partial frame discarded, no strobe emitted.
//  Back-to-back frames: a new start bit is accepted on the first fall_stb after STOP. No dead time.
//  Host-to-device transmission is not supported; kclk/kdata are never driven.
// STRUCTURE
//  ps2_pkg:
//   - typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t
//   - localparam PS2_DATA_BITS = 8
//  Sub-module ps2_input_filter (2-flop sync + FILTER_LEN debounce + fall_stb).
//   - Instantiated once for kclk; kdata uses the sync only.
//  Top level holds the FSM, shift register, bit counter, timeout counter and output registers.
// TESTING (kclk bit period 40 us half-low/half-high, clk_i 10 MHz, LSB first)
//  1 Frame 0x1C, parity 0, stop 1 -> one keycode_valid_o pulse, keycode_o=0x1C; no error strobes.
//  2 Frames 0xF0 (par 1) then 0x1C (par 0) back-to-back -> two pulses, keycode_o 0xF0 then 0x1C.
//  3 0x1C with par 1 -> parity_err_o pulse, no valid, keycode_o keeps its prior value.
//  4 Stop bit 0 on 0x29 -> frame_err_o only. Then a 5-bit partial frame + idle ->
//    frame_err_o exactly TIMEOUT_CYCLES after the last edge; following 0x29 (par 0) decodes correctly.
//  5 kclk glitch low for FILTER_LEN-2 cycles mid-frame and in IDLE -> no extra bit shifted, 0x1C still valid.
//  6 rst_i asserted after 4 data bits -> all outputs 0, no strobe; next full 0x1C frame decodes.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receive path.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

  localparam int unsigned PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchroniser plus level debounce for the raw PS/2 clock.
// fall_stb_o pulses for one cycle when the filtered level goes 1->0.
module ps2_input_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic filt_o,
  output logic fall_stb_o
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;
  logic          fall_q;

  // The filtered level only follows once the synced value has differed
  // for FILTER_LEN consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      fall_q <= 1'b0;
      if (sync_q[1] != filt_q) begin
        if (cnt_q == CW'(FILTER_LEN - 1)) begin
          filt_q <= sync_q[1];
          cnt_q  <= '0;
          fall_q <= filt_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign filt_o     = filt_q;
  assign fall_stb_o = fall_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host receiver: deframes 11-bit frames into raw bytes with
// one-cycle valid / parity-error / frame-error strobes.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic [7:0] keycode_o,
  output logic       keycode_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o
);

  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned BCW = $clog2(PS2_DATA_BITS);

  logic kclk_filt;
  logic fall_stb;

  ps2_input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_kclk_filter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .raw_i      (kclk_i),
    .filt_o     (kclk_filt),
    .fall_stb_o (fall_stb)
  );

  logic [1:0]               kdata_sync_q;
  ps2_rx_state_t            state_q;
  logic [PS2_DATA_BITS-1:0] shreg_q;
  logic [BCW-1:0]           bit_cnt_q;
  logic                     par_q;
  logic [TW-1:0]            to_cnt_q;
  logic [7:0]               keycode_q;
  logic                     valid_q;
  logic                     perr_q;
  logic                     ferr_q;
  logic                     kd;

  assign kd = kdata_sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kdata_sync_q <= '1;
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      keycode_q    <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      kdata_sync_q <= {kdata_sync_q[0], kdata_i};
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;

      // Timeout only fires on cycles without a falling edge, so it never
      // contends with the edge-driven transitions below.
      if (state_q == IDLE || fall_stb) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        to_cnt_q <= '0;
        state_q  <= IDLE;
        ferr_q   <= 1'b1;
      end else begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end

      if (fall_stb) begin
        case (state_q)
          IDLE: begin
            if (!kd) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shreg_q   <= {kd, shreg_q[PS2_DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + BCW'(1);
            if (bit_cnt_q == BCW'(PS2_DATA_BITS - 1)) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= kd;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!kd) begin
              ferr_q <= 1'b1;
            end else if (^{shreg_q, par_q}) begin
              keycode_q <= shreg_q;
              valid_q   <= 1'b1;
            end else begin
              perr_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign keycode_o       = keycode_q;
  assign keycode_valid_o = valid_q;
  assign parity_err_o    = perr_q;
  assign frame_err_o     = ferr_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Scoreboard bench for ps2_keycode_rx: frames are bit-banged at 40 us per bit.
`timescale 1ns/1ps
module tb_ps2_keycode_rx;

  localparam int unsigned FILTER_LEN     = 8;
  localparam int unsigned TIMEOUT_CYCLES = 20000;
  // raw kclk fall -> 2 sync + FILTER_LEN filter cycles -> FSM edge
  localparam int          EDGE_LAT       = 3 + FILTER_LEN;
  localparam logic [2:0]  EV_VALID = 3'b100, EV_PERR = 3'b010, EV_FERR = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kclk = 1'b1;
  logic       kdata = 1'b1;
  logic [7:0] keycode;
  logic       valid, perr, ferr;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;
  int         last_fall_cyc = 0;
  int         ferr_cyc = 0;
  bit         ferr_seen = 1'b0;
  logic [7:0] exp_key = 8'h00;
  logic [10:0] sb_q[$];

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_keycode_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .kclk_i          (kclk),
    .kdata_i         (kdata),
    .keycode_o       (keycode),
    .keycode_valid_o (valid),
    .parity_err_o    (perr),
    .frame_err_o     (ferr)
  );

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (valid || perr || ferr)) begin
      if (ferr) begin
        ferr_seen = 1'b1;
        ferr_cyc  = cyc;
      end
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_strobe: got {valid,perr,ferr}=%b key=%h, none expected", {valid, perr, ferr}, keycode);
      end else begin
        logic [10:0] e;
        e = sb_q.pop_front();
        if ({valid, perr, ferr} !== e[10:8]) begin
          tests_failed++;
          $display("FAIL strobe_kind: got %b expected %b", {valid, perr, ferr}, e[10:8]);
        end
        if (e[10:8] == EV_VALID) begin
          tests_run++;
          if (keycode !== e[7:0]) begin
            tests_failed++;
            $display("FAIL keycode_on_valid: got %h expected %h", keycode, e[7:0]);
          end
        end
      end
    end
  end

  task automatic bit_slot(input logic b, input bit glitch);
    kdata = b;
    repeat (100) @(negedge clk);
    kclk = 1'b0;
    last_fall_cyc = cyc;
    repeat (200) @(negedge clk);
    kclk = 1'b1;
    if (glitch) begin
      repeat (40) @(negedge clk);
      kclk = 1'b0;
      repeat (FILTER_LEN - 2) @(negedge clk);
      kclk = 1'b1;
      repeat (60 - (FILTER_LEN - 2)) @(negedge clk);
    end else begin
      repeat (100) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) bit_slot(bits[i], i == glitch_bit);
    kdata = 1'b1;
  endtask

  task automatic good_frame(input logic [7:0] d, input int glitch_bit);
    sb_q.push_back({EV_VALID, d});
    exp_key = d;
    send_frame(d, ~(^d), 1'b1, 11, glitch_bit);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_missing_strobes: %0d outstanding, expected 0", name, sb_q.size());
      sb_q.delete();
    end
    repeat (50) @(negedge clk);
    tests_run++;
    if (keycode !== exp_key) begin
      tests_failed++;
      $display("FAIL %s_keycode_hold: got %h expected %h", name, keycode, exp_key);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({keycode, valid, perr, ferr} !== 11'h0) begin
      tests_failed++;
      $display("FAIL %s: got key=%h v=%b p=%b f=%b expected all 0", name, keycode, valid, perr, ferr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_single_frame();
    good_frame(8'h1C, -1);
    drain("single");
  endtask

  task automatic test_back_to_back();
    good_frame(8'hF0, -1);
    good_frame(8'h1C, -1);
    drain("back_to_back");
  endtask

  task automatic test_parity_error();
    sb_q.push_back({EV_PERR, 8'h00});
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
    drain("parity_err");
  endtask

  task automatic test_frame_errors();
    int d;
    sb_q.push_back({EV_FERR, 8'h00});
    send_frame(8'h29, 1'b0, 1'b0, 11, -1);
    drain("stop_bit_err");
    ferr_seen = 1'b0;
    sb_q.push_back({EV_FERR, 8'h00});
    send_frame(8'h29, 1'b0, 1'b1, 5, -1);
    for (int i = 0; i < TIMEOUT_CYCLES + 500 && !ferr_seen; i++) @(negedge clk);
    tests_run++;
    if (!ferr_seen) begin
      tests_failed++;
      $display("FAIL timeout_strobe: no frame_err within bound, expected one");
    end else begin
      d = ferr_cyc - last_fall_cyc;
      tests_run++;
      if (d != TIMEOUT_CYCLES + EDGE_LAT) begin
        tests_failed++;
        $display("FAIL timeout_latency: got %0d cycles expected %0d", d, TIMEOUT_CYCLES + EDGE_LAT);
      end
    end
    drain("timeout");
    good_frame(8'h29, -1);
    drain("after_timeout");
  endtask

  task automatic test_glitch();
    kclk = 1'b0;
    repeat (FILTER_LEN - 2) @(negedge clk);
    kclk = 1'b1;
    repeat (200) @(negedge clk);
    good_frame(8'h1C, 4);
    drain("glitch");
  endtask

  task automatic test_reset_mid_frame();
    good_frame(8'hF0, -1);
    drain("pre_reset");
    send_frame(8'h1C, 1'b0, 1'b1, 5, -1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_frame");
    @(negedge clk);
    rst = 1'b0;
    exp_key = 8'h00;
    repeat (1000) @(negedge clk);
    check_all_zero("no_strobe_after_reset");
    good_frame(8'h1C, -1);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_parity_error();
    test_frame_errors();
    test_glitch();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
